// File: rtl/pwm_ramp_controller_if.sv
// Ramp command handshake: target width and periods-per-step, valid/ready.
// Master offers the command, slave (the controller) accepts when ready.
interface pwm_ramp_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_target;
  logic [3:0] cmd_step_periods;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step_periods,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step_periods,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_ramp_controller.sv
// Ramps the PWM duty (pulse_width) toward a commanded target one unit per N periods.
// Duty updates land only on period boundaries; commands are accepted only while idle.
module pwm_ramp_controller #(
  parameter int PERIOD_CYCLES = 2000,
  parameter int MAX_WIDTH     = 10
) (
  input  logic                        clk_1MHz,
  input  logic                        reset,
  pwm_ramp_controller_if.slave        cmd,
  input  logic                        abort,
  output logic [3:0]                  pulse_width,
  output logic                        period_tick,
  output logic                        busy,
  output logic                        done
);

  localparam int             CW      = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0]  LP_LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [3:0]     LP_MAX  = (MAX_WIDTH > 15) ? 4'd15 : 4'(MAX_WIDTH);

  typedef enum logic {S_IDLE, S_RAMP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_pw;
  logic [3:0]    r_target;
  logic [3:0]    r_step;
  logic [3:0]    r_hold;
  logic          r_done;

  logic          w_tick;
  logic [3:0]    w_cmd_target;
  logic [3:0]    w_next;
  logic [3:0]    w_step_last;

  assign w_tick       = (r_cnt == LP_LAST);
  assign w_cmd_target = (cmd.cmd_target > LP_MAX) ? LP_MAX : cmd.cmd_target;
  assign w_next       = (r_pw < r_target) ? r_pw + 4'd1 :
                        (r_pw > r_target) ? r_pw - 4'd1 : r_pw;
  assign w_step_last  = r_step - 4'd1;

  always_ff @(posedge clk_1MHz) begin
    if (reset || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Abort has priority over the tick so an aborted ramp never takes one more step.
  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pw     <= 4'd0;
      r_target <= 4'd0;
      r_step   <= 4'd0;
      r_hold   <= 4'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            r_target <= w_cmd_target;
            r_step   <= cmd.cmd_step_periods;
            r_hold   <= 4'd0;
            if (w_cmd_target == r_pw) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RAMP;
            end
          end
        end
        S_RAMP: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (r_step == 4'd0) begin
              r_pw    <= r_target;
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else if (r_hold == w_step_last) begin
              r_hold <= 4'd0;
              r_pw   <= w_next;
              if (w_next == r_target) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_hold <= r_hold + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign busy          = (r_state == S_RAMP);
  assign pulse_width   = r_pw;
  assign period_tick   = w_tick;
  assign done          = r_done;

endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 2000: clk_1MHz cycles per PWM period (500 Hz frame).
REQ-002 SHALL have parameter MAX_WIDTH, default 10: upper clamp on pulse_width.
REQ-003 SHALL have one clock and a synchronous, active-high reset; no other clock domains.
REQ-004 SHALL have port clk_1MHz, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1 bit: ramp command offered.
REQ-007 SHALL have port cmd_ready, output, 1 bit: controller accepts a command this cycle.
REQ-008 SHALL have port cmd_target, input, 4 bits: requested final pulse_width.
REQ-009 SHALL have port cmd_step_periods, input, 4 bits: PWM periods per unit step; 0 means jump.
REQ-010 SHALL have port abort, input, 1 bit: cancels an active ramp.
REQ-011 SHALL have port pulse_width, output, 4 bits: drives the PWM generator duty input.
REQ-012 SHALL have port period_tick, output, 1 bit: one-cycle pulse on the last cycle of each period.
REQ-013 SHALL have port busy, output, 1 bit: ramp in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a ramp completes.

Function
REQ-015 Period counter SHALL count 0..PERIOD_CYCLES-1 and wrap to 0.
- Free-running, independent of state.
- period_tick is high exactly when the count equals PERIOD_CYCLES-1.
REQ-016 States SHALL be IDLE and RAMP.
- cmd_ready = (state==IDLE).
- busy = (state==RAMP).
REQ-017 Handshake SHALL occur on an edge where cmd_valid && cmd_ready.
- Latch target = min(cmd_target, MAX_WIDTH) and step_periods.
- Clear hold counter; enter RAMP next cycle.
REQ-018 If the latched target equals pulse_width at acceptance, SHALL stay IDLE and pulse done the next cycle; pulse_width unchanged.
REQ-019 pulse_width SHALL change only on an edge where period_tick=1, so each new value takes effect at period count 0.
REQ-020 In RAMP on each tick SHALL apply the following:
- step_periods=0: pulse_width <= target.
- Otherwise, if hold==step_periods-1: hold <= 0 and pulse_width moves one unit toward target.
- Otherwise: hold <= hold+1.
REQ-021 When an update makes pulse_width equal target, SHALL return to IDLE and raise done for exactly the following cycle.
REQ-022 pulse_width SHALL never exceed MAX_WIDTH and SHALL never wrap below 0 or above 15.
REQ-023 cmd_valid during RAMP SHALL be ignored; no latching and no side effects.
REQ-024 abort in RAMP SHALL take effect next cycle:
- Return to IDLE and hold the current pulse_width.
- done stays 0.
REQ-025 abort together with period_tick SHALL resolve with abort winning; no pulse_width update.
REQ-026 abort in IDLE SHALL have no effect.
REQ-027 abort and cmd_valid in the same IDLE cycle SHALL still accept the command.

Reset
REQ-028 While reset=1 at an edge, SHALL set the following:
- state IDLE.
- pulse_width 0, period count 0, hold 0.
- period_tick 0, done 0, busy 0.
- cmd_ready 1 from the following cycle.
REQ-029 Reset mid-ramp SHALL discard the latched command with no done pulse.
REQ-030 After reset, the first period_tick SHALL occur PERIOD_CYCLES-1 cycles after the first edge with reset=0.

Verification
REQ-031 Reset, then target=5, step=1 SHALL produce the following:
- pulse_width 1,2,3,4,5 on five consecutive ticks, 2000 cycles apart.
- done high exactly one cycle after the fifth tick edge.
REQ-032 From 5, target=2, step=3 SHALL produce the following:
- pulse_width 4 at the 3rd tick, 3 at the 6th, 2 at the 9th.
- busy=1 throughout; done once.
REQ-033 From 2, target=9, step=0 SHALL produce the following:
- pulse_width 9 at the first tick.
- Done the next cycle; no intermediate values.
REQ-034 From 0, target=14, step=1 SHALL produce the following:
- Ramp stops at 10 (MAX_WIDTH).
- done after the 10th tick; value never exceeds 10.
REQ-035 From 0, target=8, step=1 with abort on the same cycle as the 3rd tick SHALL produce the following:
- pulse_width holds 2; done never pulses; cmd_ready=1.
- A new target=2 command then pulses done without any change.
REQ-036 Reset asserted during a ramp at pulse_width=6 SHALL produce the following:
- pulse_width 0; busy 0; no done.
- First tick 1999 cycles after reset deasserts.
